dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Controller and two-requester arbiter in front of the single-port, word-only data memory. It shares the memory between the core load/store port (port 0) and the loader/debug port (port 1). It turns byte and halfword stores into read-modify-write sequences and aligns and extends sub-word load data. It drives the data memory's `mem_read`/`mem_write`/address/write-data inputs and consumes its combinational read data.

## Interface
- `RR`, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 wins.
- `clk` input, 1: single clock; all state changes on its rising edge.
- `rst_n` input, 1: asynchronous active-low reset.
- `p0_req` / `p1_req` input, 1: request; held with its fields stable until that port's `gnt`.
- `p0_we` / `p1_we` input, 1: 1 = store, 0 = load.
- `p0_size` / `p1_size` input, 2: 00 byte, 01 half, 10 word; 11 is treated as misaligned.
- `p0_uns` / `p1_uns` input, 1: load zero-extend when 1, sign-extend when 0.
- `p0_addr` / `p1_addr` input, 32: byte address.
- `p0_wdata` / `p1_wdata` input, 32: store data, right-justified.
- `p0_gnt` / `p1_gnt` output, 1: request accepted (combinational, one cycle).
- `p0_done` / `p1_done` output, 1: one-cycle completion pulse (registered).
- `p0_err` / `p1_err` output, 1: valid with `done`; 1 = misaligned, no memory access made.
- `p0_rdata` / `p1_rdata` output, 32: load result, valid with `done` when the op was a load.
- `mem_read` output, 1: memory read enable.
- `mem_write` output, 1: memory write enable.
- `mem_addr` output, 32: word address, bits [1:0] forced to 0.
- `mem_wdata` output, 32: word to write.
- `mem_rdata` input, 32: combinational memory read data.

## Operation
- States: IDLE, ACCESS, RMW_WR.
- **IDLE**
  - Arbitrate among asserted reqs and assert the winner's `gnt` in the same cycle.
  - At the edge, latch the winner's op fields and port id, then go to ACCESS.
  - Round-robin: on contention the port that did not win last wins. The last-winner register resets to 1, so port 0 wins the first tie. A lone request always wins.
- **Misalignment** (checked on latched fields): half with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - ACCESS drives no `mem_read`/`mem_write`.
  - Returns to IDLE and pulses `done`+`err` next cycle; `rdata` = 0.
- **ACCESS, load**
  - `mem_read`=1. At the edge, capture the extracted lane: byte lane k = bits [8k+7:8k] with k = addr[1:0]; half lane h = bits [16h+15:16h] with h = addr[1]. Little-endian.
  - Extend to 32 bits per `uns`.
  - Go to IDLE.
- **ACCESS, word store**: `mem_write`=1, `mem_wdata`=wdata; go to IDLE.
- **ACCESS, sub-word store**
  - `mem_read`=1; capture `mem_rdata`.
  - Replace the addressed lane with wdata[7:0] or wdata[15:0]; other lanes unchanged.
  - Go to RMW_WR.
- **RMW_WR**: `mem_write`=1, `mem_wdata` = merged word; go to IDLE.
- Only the latched port gets `done`/`rdata`. `rdata` holds its last value until the next load completion for that port.
- `mem_read` and `mem_write` are never both 1. Both are 0 in IDLE.

## Timing
- Reset (async, immediate): state=IDLE, last-winner=1.
  - All `gnt`, `done`, `err`, `mem_read`, `mem_write` = 0.
  - `rdata`, `mem_addr`, `mem_wdata` = 0.
- Reset asserted mid-RMW aborts the op: no write issued, no `done`.
- Cycle c = grant.
  - Load, word store, or misaligned: memory access in c+1, `done` in c+2.
  - Sub-word store: read in c+1, write in c+2, `done` in c+3.
- A new grant is possible in the same cycle as a previous `done` (IDLE overlaps).
  - Sustained throughput: 1 op per 2 cycles, or per 3 cycles for sub-word stores.
- Requests arriving in ACCESS/RMW_WR wait; no `gnt` outside IDLE.
- Store followed by a load to the same word: the load reads the new value, because the write completes before the load's ACCESS.

## Test plan
- **Reset and load**
  - Stimulus: reset; preload mem[0x10]=0x8899AABB; p0 load byte uns=0 addr 0x13.
  - Required: `gnt` c, `mem_read` c+1, `done` c+2, `rdata`=0xFFFFFF88. Repeat with uns=1 → 0x00000088.
- **Halfword RMW store**
  - Stimulus: mem[0x20]=0x11223344; p1 store half addr 0x22 wdata 0xABCD.
  - Required: read c+1, write c+2 with `mem_wdata`=0xABCD3344, `done` c+3, then mem[0x20]=0xABCD3344.
- **Contention**: p0 and p1 both hold reqs continuously with RR=1.
  - Required: grants go p0, p1, p0, p1 on cycles 0, 2, 4, 6 (word loads).
  - With RR=0: p0 is granted every time while it holds req.
- **Misaligned word store**: addr 0x06.
  - Required: no `mem_write` ever; `done`+`err` at c+2; memory unchanged.
- **Reset mid-RMW**: assert `rst_n`=0 during RMW_WR.
  - Required: `mem_write` drops immediately, the target word is unchanged, and no `done` is pulsed.
- **Back-to-back**: word store 0xDEADBEEF to 0x40, then a load of 0x40 granted in the `done` cycle.
  - Required: `rdata`=0xDEADBEEF.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: arbitrates two requesters onto a single-port, word-only data memory.
// Sub-word stores become read-modify-write; sub-word loads are lane-aligned and extended.
module dmem_ctrl #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_uns,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_uns,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RMW_WR = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last, r_port, r_we, r_uns;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_merge, r_rdata0, r_rdata1;
  logic        r_done0, r_done1, r_err0, r_err1;
  logic        w_any, w_sel, w_mis, w_sub, w_fin;

  function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic [31:0] wdata);
    logic [31:0] res;
    res = word;
    if (size == 2'b00) begin
      res[{lane, 3'b000} +: 8] = wdata[7:0];
    end else if (lane[1]) begin
      res[31:16] = wdata[15:0];
    end else begin
      res[15:0] = wdata[15:0];
    end
    return res;
  endfunction

  // Arbitration: the port that did not win last takes a tie when round-robin is enabled.
  always_comb begin
    w_any = p0_req | p1_req;
    if (p0_req && p1_req) begin
      w_sel = RR ? ~r_last : 1'b0;
    end else begin
      w_sel = p1_req;
    end
  end

  assign p0_gnt = (r_state == S_IDLE) && w_any && !w_sel;
  assign p1_gnt = (r_state == S_IDLE) && w_any && w_sel;

  assign w_mis = (r_size == 2'b11) || ((r_size == 2'b01) && r_addr[0]) ||
                 ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
  assign w_sub = r_we && !w_mis && (r_size != 2'b10);
  assign w_fin = ((r_state == S_ACCESS) && !w_sub) || (r_state == S_RMW_WR);

  // Next-state and memory strobes.
  always_comb begin
    w_state_nxt = r_state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = r_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ACCESS;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCESS: begin
        mem_read  = !w_mis && (!r_we || w_sub);
        mem_write = !w_mis && r_we && !w_sub;
        if (w_sub) begin
          w_state_nxt = S_RMW_WR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RMW_WR: begin
        mem_write   = 1'b1;
        mem_wdata   = r_merge;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem_addr = {r_addr[31:2], 2'b00};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the winning request and remember who won.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
    end else if ((r_state == S_IDLE) && w_any) begin
      r_last  <= w_sel;
      r_port  <= w_sel;
      r_we    <= w_sel ? p1_we    : p0_we;
      r_size  <= w_sel ? p1_size  : p0_size;
      r_uns   <= w_sel ? p1_uns   : p0_uns;
      r_addr  <= w_sel ? p1_addr  : p0_addr;
      r_wdata <= w_sel ? p1_wdata : p0_wdata;
    end
  end

  // Merge the store lane into the word read during ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_merge <= 32'h0000_0000;
    end else if ((r_state == S_ACCESS) && w_sub) begin
      r_merge <= f_merge(mem_rdata, r_size, r_addr[1:0], r_wdata);
    end
  end

  // Completion pulses and per-port load results; rdata holds between load completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= 32'h0000_0000;
      r_rdata1 <= 32'h0000_0000;
    end else begin
      r_done0 <= w_fin && !r_port;
      r_done1 <= w_fin && r_port;
      r_err0  <= w_fin && !r_port && w_mis;
      r_err1  <= w_fin && r_port && w_mis;
      if (w_fin && w_mis) begin
        if (r_port) r_rdata1 <= 32'h0000_0000;
        else        r_rdata0 <= 32'h0000_0000;
      end else if (w_fin && !r_we) begin
        if (r_port) r_rdata1 <= f_extract(mem_rdata, r_size, r_addr[1:0], r_uns);
        else        r_rdata0 <= f_extract(mem_rdata, r_size, r_addr[1:0], r_uns);
      end
    end
  end

  assign p0_done  = r_done0;
  assign p1_done  = r_done1;
  assign p0_err   = r_err0;
  assign p1_err   = r_err1;
  assign p0_rdata = r_rdata0;
  assign p1_rdata = r_rdata1;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus random ops against
// an operation-level reference memory model.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p0_uns, p1_req, p1_we, p1_uns;
  logic [1:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        fp_p0_gnt, fp_p0_done, fp_p0_err, fp_p1_gnt, fp_p1_done, fp_p1_err;
  logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_mem_read, fp_mem_write;
  logic [31:0] fp_mem_rdata;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.RR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
    .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_ctrl #(.RR(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(fp_p0_gnt), .p0_done(fp_p0_done),
    .p0_err(fp_p0_err), .p0_rdata(fp_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(fp_p1_gnt), .p1_done(fp_p1_done),
    .p1_err(fp_p1_err), .p1_rdata(fp_p1_rdata),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata)
  );

  assign fp_mem_rdata = 32'h0000_0000;

  // Memory behind the DUT: combinational read, clocked write, backdoor preload.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[9:2]];

  function automatic logic gnt_of(input int p);
    return (p == 1) ? p1_gnt : p0_gnt;
  endfunction
  function automatic logic done_of(input int p);
    return (p == 1) ? p1_done : p0_done;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 1) ? p1_err : p0_err;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p == 1) ? p1_rdata : p0_rdata;
  endfunction

  task automatic set_req(input int port, input logic v, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 1) begin
      p1_req = v; p1_we = we; p1_size = size; p1_uns = uns; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = v; p0_we = we; p0_size = size; p0_uns = uns; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = addr[9:2]; pl_data = data;
    ref_mem[addr[9:2]] = data;
    @(negedge clk);
    pl_en = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // One request from issue to done, checked against the reference model.
  task automatic do_op(input int port, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, output int waited);
    logic        mis, sub, seen;
    logic [31:0] mask, v, exp_rd, exp_word, waddr;
    int          sh, w, k, reads, writes, rcyc, wcyc, lat;
    w     = int'(addr[9:2]);
    sh    = int'(addr[1:0]) * 8;
    waddr = {addr[31:2], 2'b00};
    mask  = (size == 2'b00) ? 32'h0000_00FF : (size == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    mis   = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    sub   = we && !mis && (size != 2'b10);
    lat   = sub ? 3 : 2;
    exp_rd   = 32'h0;
    exp_word = ref_mem[w];
    if (!mis && !we) begin
      v = (ref_mem[w] >> sh) & mask;
      if (!uns && size != 2'b10 && v[(size == 2'b00) ? 7 : 15]) v = v | ~mask;
      exp_rd = v;
    end else if (!mis) begin
      exp_word = (ref_mem[w] & ~(mask << sh)) | ((wdata & mask) << sh);
      ref_mem[w] = exp_word;
    end
    set_req(port, 1'b1, we, size, uns, addr, wdata);
    #1;
    waited = 0;
    while (!gnt_of(port) && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    checks++;
    if (!gnt_of(port)) begin
      failures++;
      $display("FAIL gnt_timeout port=%0d got=0 want=1", port);
      set_req(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      return;
    end
    checks++;
    if (gnt_of(1 - port) !== 1'b0) begin
      failures++; $display("FAIL other_gnt port=%0d got=1 want=0", 1 - port);
    end
    @(negedge clk);
    set_req(port, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1;
    k = 1; reads = 0; writes = 0; rcyc = 0; wcyc = 0; seen = 1'b0;
    while (k <= 5 && !seen) begin
      checks++;
      if (mem_read && mem_write) begin
        failures++; $display("FAIL rd_wr_both cycle=%0d got=1 want=0", k);
      end
      if (mem_read) begin
        reads++; rcyc = k; checks++;
        if (mem_addr !== waddr) begin
          failures++; $display("FAIL rd_addr got=%h want=%h", mem_addr, waddr);
        end
      end
      if (mem_write) begin
        writes++; wcyc = k; checks++;
        if (mem_wdata !== exp_word || mem_addr !== waddr) begin
          failures++;
          $display("FAIL wr_data got=%h@%h want=%h@%h", mem_wdata, mem_addr, exp_word, waddr);
        end
      end
      checks++;
      if (done_of(1 - port) !== 1'b0) begin
        failures++; $display("FAIL other_done port=%0d got=1 want=0", 1 - port);
      end
      if (done_of(port)) seen = 1'b1;
      else begin
        @(negedge clk); #1; k++;
      end
    end
    checks++;
    if (!seen || k != lat) begin
      failures++; $display("FAIL done_latency got=%0d seen=%0d want=%0d", k, seen, lat);
    end
    checks++;
    if (err_of(port) !== mis) begin
      failures++; $display("FAIL err got=%0d want=%0d", err_of(port), mis);
    end
    checks++;
    if (reads != ((!mis && (!we || sub)) ? 1 : 0) || (reads == 1 && rcyc != 1)) begin
      failures++; $display("FAIL read_count got=%0d@%0d want=%0d", reads, rcyc, (!mis && (!we || sub)) ? 1 : 0);
    end
    checks++;
    if (writes != ((!mis && we) ? 1 : 0) || (writes == 1 && wcyc != (sub ? 2 : 1))) begin
      failures++; $display("FAIL write_count got=%0d@%0d want=%0d", writes, wcyc, (!mis && we) ? 1 : 0);
    end
    if (!we) begin
      checks++;
      if (rdata_of(port) !== exp_rd) begin
        failures++; $display("FAIL rdata port=%0d got=%h want=%h", port, rdata_of(port), exp_rd);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pl_en = 1'b0; pl_idx = 8'h00; pl_data = 32'h0;
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #12;
    checks++;
    if ({p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, mem_read, mem_write} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctl got=%b want=00000000",
               {p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err, mem_read, mem_write});
    end
    checks++;
    if ((p0_rdata | p1_rdata | mem_addr | mem_wdata) !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h %h %h %h want=0", p0_rdata, p1_rdata, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_load();
    int wt;
    preload(32'h10, 32'h8899_AABB);
    do_op(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, wt);
    checks++;
    if (wt != 0 || p0_rdata !== 32'hFFFF_FF88) begin
      failures++; $display("FAIL load_sext got=%h wait=%0d want=ffffff88", p0_rdata, wt);
    end
    do_op(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, wt);
    checks++;
    if (p0_rdata !== 32'h0000_0088) begin
      failures++; $display("FAIL load_zext got=%h want=00000088", p0_rdata);
    end
  endtask

  task automatic test_rmw_half();
    int wt;
    preload(32'h20, 32'h1122_3344);
    do_op(1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_ABCD, wt);
    checks++;
    if (mem[8] !== 32'hABCD_3344) begin
      failures++; $display("FAIL rmw_half_mem got=%h want=abcd3344", mem[8]);
    end
  endtask

  task automatic test_contention();
    logic e0, e1;
    do_reset();
    set_req(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      e0 = (i % 4 == 0);
      e1 = (i % 4 == 2);
      checks++;
      if (p0_gnt !== e0 || p1_gnt !== e1) begin
        failures++; $display("FAIL rr_gnt cycle=%0d got=%b%b want=%b%b", i, p0_gnt, p1_gnt, e0, e1);
      end
      checks++;
      if (fp_p0_gnt !== (i % 2 == 0) || fp_p1_gnt !== 1'b0) begin
        failures++; $display("FAIL fp_gnt cycle=%0d got=%b%b want=%b0", i, fp_p0_gnt, fp_p1_gnt, (i % 2 == 0));
      end
      @(negedge clk);
    end
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_misaligned();
    int wt;
    preload(32'h04, 32'hCAFE_F00D);
    do_op(0, 1'b1, 2'b10, 1'b0, 32'h06, 32'h1234_5678, wt);
    checks++;
    if (mem[1] !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL misaligned_mem got=%h want=cafef00d", mem[1]);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int n;
    preload(32'h30, 32'h1122_3344);
    set_req(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_0055);
    #1;
    n = 0;
    while (!p0_gnt && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    checks++;
    if (mem_write !== 1'b1) begin
      failures++; $display("FAIL rmw_wr_phase got=%b want=1", mem_write);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0) begin
      failures++; $display("FAIL rst_drop_write got=%b want=0", mem_write);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (p0_done !== 1'b0) begin
        failures++; $display("FAIL rst_no_done cycle=%0d got=1 want=0", i);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (mem[12] !== 32'h1122_3344) begin
      failures++; $display("FAIL rst_mem_unchanged got=%h want=11223344", mem[12]);
    end
  endtask

  task automatic test_back_to_back();
    int wt;
    do_op(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, wt);
    do_op(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, wt);
    checks++;
    if (wt != 0 || p1_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL back_to_back got=%h wait=%0d want=deadbeef", p1_rdata, wt);
    end
  endtask

  task automatic test_random();
    int          wt, r;
    logic [1:0]  sz;
    for (int i = 0; i < 16; i++) preload(32'h100 + 32'(i * 4), $urandom);
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      do_op($urandom_range(0, 1), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            32'h100 + 32'($urandom_range(0, 63)), $urandom, wt);
    end
    for (int i = 64; i < 80; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin
        failures++; $display("FAIL rand_mem idx=%0d got=%h want=%h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    test_reset();
    test_load();
    test_rmw_half();
    test_contention();
    test_misaligned();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
